// File: rtl/vram_cpu_port.sv
// CPU-side initiator for the tile RAM: decodes Z80 cycles to the tile RAM window,
// holds WAIT while the tile generator owns the RAM, then issues one single-cycle access.
module vram_cpu_port #(
    parameter logic [15:0] BASE     = 16'h7400,
    parameter int unsigned MAX_WAIT = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mreqn,
    input  logic        cpu_rdn,
    input  logic        cpu_wrn,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_dout_en,
    output logic        waitn,
    input  logic        vram_busy,
    output logic        rdn,
    output logic        wrn,
    output logic        tile_ena,
    output logic [9:0]  addr,
    output logic [7:0]  din,
    input  logic [7:0]  dout,
    output logic        timeout
);

    localparam int unsigned      CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        STALL,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             hit;
    logic             wr_flag;
    logic             wr_sel;
    logic             issue_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX) begin
            return CNT_MAX;
        end
        return v + CNT_W'(1);
    endfunction

    assign hit = ~mreqn & (~cpu_rdn | ~cpu_wrn) & (cpu_addr[15:10] == BASE[15:10]);

    // WAIT must fall in the same cycle as the hit and must read released during reset.
    assign waitn       = ~(hit & (state != DONE) & rst_n);
    assign cpu_dout_en = (state == DONE) & ~wr_flag;

    assign cnt_inc   = sat_inc(stall_cnt);
    assign issue_nxt = (state_nxt == ISSUE);
    // In IDLE the direction flag is not latched yet, so take it straight from the bus.
    assign wr_sel    = (state == IDLE) ? ~cpu_wrn : wr_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_nxt = vram_busy ? STALL : ISSUE;
                end
            end
            STALL: begin
                if (!hit) begin
                    state_nxt = IDLE;
                end else if (!vram_busy) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE: begin
                if (!hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and stall supervision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            din       <= '0;
            wr_flag   <= 1'b0;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            if (state == IDLE && hit) begin
                addr    <= cpu_addr[9:0];
                din     <= cpu_din;
                wr_flag <= ~cpu_wrn;
            end
            if (state == IDLE && hit && vram_busy) begin
                stall_cnt <= '0;
            end else if (state == STALL) begin
                stall_cnt <= cnt_inc;
                if (cnt_inc >= CNT_TRIP) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    // RAM strobes are registered so the tile generator sees clean one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_ena <= 1'b0;
            rdn      <= 1'b1;
            wrn      <= 1'b1;
        end else begin
            tile_ena <= issue_nxt;
            rdn      <= ~(issue_nxt & ~wr_sel);
            wrn      <= ~(issue_nxt & wr_sel);
        end
    end

    // Read data capture, one clock after the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_dout <= '0;
        end else if (state == CAPTURE && !wr_flag) begin
            cpu_dout <= dout;
        end
    end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Self-checking bench for vram_cpu_port: bench-side RAM plus a transaction-level model
// of expected stall length, strobe, read data and timeout.
module tb_vram_cpu_port;

    localparam int unsigned WIN_BASE = 32'h7400;
    localparam int unsigned WIN_SIZE = 1024;
    localparam int          MAXW     = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mreqn;
    logic        cpu_rdn;
    logic        cpu_wrn;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_dout_en;
    logic        waitn;
    logic        vram_busy;
    logic        rdn;
    logic        wrn;
    logic        tile_ena;
    logic [9:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout = 8'h00;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram     [WIN_SIZE] = '{default: 8'h00};
    logic [7:0] exp_mem [WIN_SIZE] = '{default: 8'h00};
    logic       exp_timeout = 1'b0;

    // Results of the last run_access
    int         r_low, r_nstb, r_scyc;
    logic       r_srd, r_swr, r_en_done, r_en_after, r_tmo, r_hung;
    logic [9:0] r_sa;
    logic [7:0] r_sd, r_rdata;

    vram_cpu_port #(.BASE(16'h7400), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .mreqn(mreqn), .cpu_rdn(cpu_rdn), .cpu_wrn(cpu_wrn),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_dout_en(cpu_dout_en),
        .waitn(waitn), .vram_busy(vram_busy), .rdn(rdn), .wrn(wrn), .tile_ena(tile_ena),
        .addr(addr), .din(din), .dout(dout), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Tile RAM as seen from the tile generator's CPU port
    always @(posedge clk) begin
        if (tile_ena && !wrn) ram[addr] <= din;
        if (tile_ena && !rdn) dout <= ram[addr];
    end

    function automatic logic model_hit(input logic rd, input logic wr, input logic [15:0] a);
        int unsigned ai;
        ai = a;
        return (rd || wr) && (ai >= WIN_BASE) && (ai < WIN_BASE + WIN_SIZE);
    endfunction

    task automatic idle_bus();
        mreqn = 1'b1; cpu_rdn = 1'b1; cpu_wrn = 1'b1; vram_busy = 1'b0;
    endtask

    // Drives one Z80 cycle with vram_busy held for the first b cycles, and records what the DUT did.
    task automatic run_access(input logic do_rd, input logic do_wr, input logic [15:0] a,
                              input logic [7:0] d, input int b);
        int k;
        logic done;
        r_low = 0; r_nstb = 0; r_scyc = -1; r_srd = 0; r_swr = 0; r_sa = '0; r_sd = '0;
        r_rdata = '0; r_en_done = 0; r_hung = 0;
        k = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            mreqn = 1'b0; cpu_rdn = ~do_rd; cpu_wrn = ~do_wr; cpu_addr = a; cpu_din = d;
            vram_busy = (k < b);
            #1;
            if (tile_ena || !rdn || !wrn) begin
                r_nstb++; r_srd = !rdn; r_swr = !wrn; r_sa = addr; r_sd = din; r_scyc = k;
            end
            if (!waitn) r_low++;
            else begin
                done = 1; r_rdata = cpu_dout; r_en_done = cpu_dout_en;
            end
            k++;
            if (!done && k > b + 40) begin
                r_hung = 1; done = 1;
            end
        end
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            vram_busy = 1'($urandom_range(0, 1));
            #1;
            if (tile_ena || !rdn || !wrn) r_nstb++;
        end
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        #1;
        r_en_after = cpu_dout_en;
        r_tmo = timeout;
    endtask

    task automatic test_reset();
        idle_bus(); cpu_addr = '0; cpu_din = '0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (waitn !== 1'b1) begin n_fail++; $display("FAIL reset_waitn: got %b want 1", waitn); end
        n_checks++; if (rdn !== 1'b1 || wrn !== 1'b1) begin n_fail++; $display("FAIL reset_strobes: got rdn=%b wrn=%b want 1/1", rdn, wrn); end
        n_checks++; if (tile_ena !== 1'b0) begin n_fail++; $display("FAIL reset_tile_ena: got %b want 0", tile_ena); end
        n_checks++; if (addr !== 10'h0 || din !== 8'h0) begin n_fail++; $display("FAIL reset_addr_din: got %h/%h want 0/0", addr, din); end
        n_checks++; if (cpu_dout !== 8'h0 || cpu_dout_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_dout: got %h en=%b want 00 en=0", cpu_dout, cpu_dout_en); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_basic();
        run_access(1'b0, 1'b1, 16'h7440, 8'hA5, 0);
        exp_mem[10'h040] = 8'hA5;
        n_checks++; if (r_hung !== 1'b0 || r_low != 3) begin n_fail++; $display("FAIL wr_wait_len: got %0d want 3", r_low); end
        n_checks++; if (r_nstb != 1 || r_swr !== 1'b1 || r_srd !== 1'b0) begin n_fail++; $display("FAIL wr_strobe: got n=%0d wr=%b rd=%b want 1/1/0", r_nstb, r_swr, r_srd); end
        n_checks++; if (r_sa !== 10'h040 || r_sd !== 8'hA5) begin n_fail++; $display("FAIL wr_addr_data: got %h/%h want 040/a5", r_sa, r_sd); end
        n_checks++; if (r_scyc != 1) begin n_fail++; $display("FAIL wr_strobe_cycle: got %0d want 1", r_scyc); end
        n_checks++; if (r_en_done !== 1'b0 || r_tmo !== 1'b0) begin n_fail++; $display("FAIL wr_en_timeout: got en=%b tmo=%b want 0/0", r_en_done, r_tmo); end
    endtask

    task automatic test_read_stall();
        run_access(1'b0, 1'b1, 16'h77BF, 8'h3C, 0);
        exp_mem[10'h3BF] = 8'h3C;
        run_access(1'b1, 1'b0, 16'h77BF, 8'h00, 20);
        n_checks++; if (r_hung !== 1'b0 || r_low != 23) begin n_fail++; $display("FAIL rd_wait_len: got %0d want 23", r_low); end
        n_checks++; if (r_nstb != 1 || r_srd !== 1'b1 || r_swr !== 1'b0) begin n_fail++; $display("FAIL rd_strobe: got n=%0d rd=%b wr=%b want 1/1/0", r_nstb, r_srd, r_swr); end
        n_checks++; if (r_scyc != 21 || r_sa !== 10'h3BF) begin n_fail++; $display("FAIL rd_strobe_when: got cyc=%0d addr=%h want 21/3bf", r_scyc, r_sa); end
        n_checks++; if (r_rdata !== exp_mem[10'h3BF] || r_en_done !== 1'b1) begin n_fail++; $display("FAIL rd_data: got %h en=%b want %h en=1", r_rdata, r_en_done, exp_mem[10'h3BF]); end
        n_checks++; if (r_en_after !== 1'b0) begin n_fail++; $display("FAIL rd_en_release: got %b want 0", r_en_after); end
    endtask

    task automatic test_miss();
        run_access(1'b1, 1'b0, 16'h7800, 8'h00, 5);
        n_checks++; if (r_low != 0 || r_nstb != 0) begin n_fail++; $display("FAIL miss_7800: got low=%0d strobes=%0d want 0/0", r_low, r_nstb); end
        run_access(1'b0, 1'b1, 16'h73FF, 8'h99, 0);
        n_checks++; if (r_low != 0 || r_nstb != 0) begin n_fail++; $display("FAIL miss_73ff: got low=%0d strobes=%0d want 0/0", r_low, r_nstb); end
        run_access(1'b0, 1'b0, 16'h7410, 8'h99, 0);
        n_checks++; if (r_low != 0 || r_nstb != 0) begin n_fail++; $display("FAIL miss_nostrobe: got low=%0d strobes=%0d want 0/0", r_low, r_nstb); end
    endtask

    task automatic test_abort();
        int low, nstb;
        low = 0; nstb = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mreqn = 1'b0; cpu_rdn = 1'b1; cpu_wrn = 1'b0; cpu_addr = 16'h7455; cpu_din = 8'hEE;
            vram_busy = 1'b1;
            #1;
            if (!waitn) low++;
            if (tile_ena || !rdn || !wrn) nstb++;
        end
        @(negedge clk);
        mreqn = 1'b1; cpu_wrn = 1'b1;
        #1;
        n_checks++; if (waitn !== 1'b1) begin n_fail++; $display("FAIL abort_waitn: got %b want 1", waitn); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vram_busy = 1'b0;
            #1;
            if (tile_ena || !rdn || !wrn) nstb++;
        end
        n_checks++; if (low != 5 || nstb != 0) begin n_fail++; $display("FAIL abort_stall: got low=%0d strobes=%0d want 5/0", low, nstb); end
        run_access(1'b1, 1'b0, 16'h7455, 8'h00, 2);
        n_checks++; if (r_low != 5 || r_nstb != 1 || r_rdata !== exp_mem[10'h055]) begin
            n_fail++; $display("FAIL abort_next: got low=%0d n=%0d data=%h want 5/1/%h", r_low, r_nstb, r_rdata, exp_mem[10'h055]);
        end
    endtask

    task automatic test_random();
        logic rd, wr, h;
        logic [15:0] a;
        logic [7:0] d;
        int b, sel;
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 3);
            rd = (sel == 0 || sel == 2);
            wr = (sel == 1 || sel == 2);
            if ($urandom_range(0, 3) != 0) a = 16'(WIN_BASE + $urandom_range(0, WIN_SIZE - 1));
            else a = 16'($urandom);
            d = 8'($urandom);
            b = $urandom_range(0, 12);
            h = model_hit(rd, wr, a);
            run_access(rd, wr, a, d, b);
            n_checks++; if (r_hung !== 1'b0 || r_low != (h ? b + 3 : 0)) begin n_fail++; $display("FAIL rand_wait[%0d]: got %0d want %0d", t, r_low, h ? b + 3 : 0); end
            n_checks++; if (r_nstb != (h ? 1 : 0)) begin n_fail++; $display("FAIL rand_nstrobe[%0d]: got %0d want %0d", t, r_nstb, h ? 1 : 0); end
            if (h) begin
                n_checks++; if (r_swr !== wr || r_srd !== !wr || r_sa !== a[9:0] || r_scyc != b + 1) begin
                    n_fail++; $display("FAIL rand_strobe[%0d]: got wr=%b rd=%b addr=%h cyc=%0d want wr=%b addr=%h cyc=%0d", t, r_swr, r_srd, r_sa, r_scyc, wr, a[9:0], b + 1);
                end
                if (wr) begin
                    n_checks++; if (r_sd !== d) begin n_fail++; $display("FAIL rand_wdata[%0d]: got %h want %h", t, r_sd, d); end
                    exp_mem[a[9:0]] = d;
                end else begin
                    n_checks++; if (r_rdata !== exp_mem[a[9:0]]) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", t, r_rdata, exp_mem[a[9:0]]); end
                end
            end
            n_checks++; if (r_en_done !== (h && !wr) || r_en_after !== 1'b0) begin
                n_fail++; $display("FAIL rand_dout_en[%0d]: got %b/%b want %b/0", t, r_en_done, r_en_after, h && !wr);
            end
            n_checks++; if (r_tmo !== exp_timeout) begin n_fail++; $display("FAIL rand_timeout[%0d]: got %b want %b", t, r_tmo, exp_timeout); end
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 1'b1, 16'h7401, 8'h61, MAXW - 2);
        exp_mem[10'h001] = 8'h61;
        n_checks++; if (r_hung !== 1'b0 || r_low != MAXW + 1) begin n_fail++; $display("FAIL tmo_wait_510: got %0d want %0d", r_low, MAXW + 1); end
        n_checks++; if (r_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", r_tmo); end
        run_access(1'b0, 1'b1, 16'h7402, 8'h62, MAXW - 1);
        exp_mem[10'h002] = 8'h62;
        exp_timeout = 1'b1;
        n_checks++; if (r_hung !== 1'b0 || r_nstb != 1 || r_low != MAXW + 2) begin n_fail++; $display("FAIL tmo_wait_511: got low=%0d n=%0d want %0d/1", r_low, r_nstb, MAXW + 2); end
        n_checks++; if (r_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", r_tmo); end
        run_access(1'b1, 1'b0, 16'h7402, 8'h00, 0);
        n_checks++; if (r_tmo !== 1'b1 || r_rdata !== 8'h62) begin n_fail++; $display("FAIL tmo_sticky: got tmo=%b data=%h want 1/62", r_tmo, r_rdata); end
    endtask

    task automatic test_reset_in_issue();
        run_access(1'b0, 1'b1, 16'h7500, 8'h11, 0);
        exp_mem[10'h100] = 8'h11;
        @(negedge clk);
        mreqn = 1'b0; cpu_rdn = 1'b1; cpu_wrn = 1'b0; cpu_addr = 16'h7500; cpu_din = 8'h5A; vram_busy = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (tile_ena !== 1'b1 || wrn !== 1'b0) begin n_fail++; $display("FAIL rst_issue_pre: got ena=%b wrn=%b want 1/0", tile_ena, wrn); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (wrn !== 1'b1 || tile_ena !== 1'b0 || waitn !== 1'b1 || rdn !== 1'b1) begin
            n_fail++; $display("FAIL rst_issue_async: got wrn=%b ena=%b waitn=%b rdn=%b want 1/0/1/1", wrn, tile_ena, waitn, rdn);
        end
        n_checks++; if (addr !== 10'h0 || din !== 8'h0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL rst_issue_regs: got addr=%h din=%h tmo=%b want 0/0/0", addr, din, timeout);
        end
        exp_timeout = 1'b0;
        @(negedge clk);
        idle_bus();
        rst_n = 1'b1;
        @(negedge clk);
        run_access(1'b1, 1'b0, 16'h7500, 8'h00, 0);
        n_checks++; if (r_low != 3 || r_rdata !== exp_mem[10'h100]) begin n_fail++; $display("FAIL rst_dropped: got low=%0d data=%h want 3/%h", r_low, r_rdata, exp_mem[10'h100]); end
        run_access(1'b0, 1'b1, 16'h7500, 8'h5A, 1);
        exp_mem[10'h100] = 8'h5A;
        run_access(1'b1, 1'b0, 16'h7500, 8'h00, 0);
        n_checks++; if (r_rdata !== 8'h5A || r_tmo !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_write: got data=%h tmo=%b want 5a/0", r_rdata, r_tmo); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_stall();
        test_miss();
        test_abort();
        test_random();
        test_timeout();
        test_reset_in_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
